comfort_ramp_ctrl: RTL

COMFORT_RAMP_CTRL -- requirements
Module: comfort_ramp_ctrl

---
 rtl/comfort_ramp_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/comfort_ramp_ctrl.sv
// comfort_ramp_ctrl: password-gated comfort setpoint controller.
// Each of CH channels (ch0 temperature, ch1 light, ...) ramps its registered
// setpoint one LSB per STEP_DIV clocks toward a per-channel ideal value, but
// only while the authentication FSM is UNLOCKED.
// Optional feature macro COMFORT_LOCKOUT_EN: when defined, MAX_TRIES
// consecutive wrong passwords put the FSM into LOCKOUT for LOCK_CYCLES clocks.
// When undefined, wrong passwords simply leave the FSM in LOCKED and
// locked_out is tied low.
module comfort_ramp_ctrl #(
    parameter int CH          = 2,
    parameter int W           = 8,
    parameter int STEP_DIV    = 10,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      pass_in,
    input  logic [7:0]      pass_ref,
    input  logic            pass_valid,
    input  logic            lock,
    input  logic            load,
    input  logic [CH*W-1:0] ideal,
    input  logic [CH*W-1:0] sens,
    output logic [CH*W-1:0] set_out,
    output logic [CH-1:0]   busy,
    output logic            unlocked,
    output logic            locked_out
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [W-1:0]  STEP_ONE   = W'(1);

    state_t            state_r;
    state_t            state_s;
    logic [PW-1:0]     presc_r;
    logic [PW-1:0]     presc_s;
    logic [CH*W-1:0]   set_r;
    logic [CH*W-1:0]   set_s;
    logic              unlocked_r;
    logic              pass_ok_s;
    logic              tick_s;
    logic              load_ok_s;
    logic [CH-1:0]     busy_s;

`ifdef COMFORT_LOCKOUT_EN
    localparam int FW  = $clog2(MAX_TRIES + 1);
    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam logic [FW-1:0]  FAIL_LAST = FW'(MAX_TRIES - 1);
    localparam logic [FW-1:0]  FAIL_ONE  = FW'(1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [LCW-1:0] LOCK_ONE  = LCW'(1);

    logic [FW-1:0]  fail_cnt_r;
    logic [FW-1:0]  fail_cnt_s;
    logic [LCW-1:0] lock_cnt_r;
    logic [LCW-1:0] lock_cnt_s;
    logic           locked_out_r;
`endif

    assign pass_ok_s = (pass_in == pass_ref);
    // A step tick happens only while UNLOCKED, on the last prescaler count.
    assign tick_s    = (state_r == ST_UNLOCKED) && (presc_r == PRESC_LAST);
    assign load_ok_s = (state_r == ST_UNLOCKED) && load;

    // Authentication next-state and fail/lockout counter updates.
    always_comb begin
        state_s = state_r;
`ifdef COMFORT_LOCKOUT_EN
        fail_cnt_s = fail_cnt_r;
        lock_cnt_s = '0;
`endif
        case (state_r)
            ST_LOCKED: begin
`ifdef COMFORT_LOCKOUT_EN
                if (pass_valid && pass_ok_s) begin
                    state_s    = ST_UNLOCKED;
                    fail_cnt_s = '0;
                end else if (pass_valid) begin
                    if (fail_cnt_r == FAIL_LAST) begin
                        state_s    = ST_LOCKOUT;
                        fail_cnt_s = '0;
                    end else begin
                        fail_cnt_s = fail_cnt_r + FAIL_ONE;
                    end
                end else begin
                    state_s = ST_LOCKED;
                end
`else
                if (pass_valid && pass_ok_s) begin
                    state_s = ST_UNLOCKED;
                end else begin
                    state_s = ST_LOCKED;
                end
`endif
            end
            ST_UNLOCKED: begin
                // lock wins over any password strobe in the same cycle
                if (lock) begin
                    state_s = ST_LOCKED;
                end else if (pass_valid && !pass_ok_s) begin
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_UNLOCKED;
                end
            end
`ifdef COMFORT_LOCKOUT_EN
            ST_LOCKOUT: begin
                // stays exactly LOCK_CYCLES cycles; pass_valid is ignored here
                if (lock_cnt_r == LOCK_LAST) begin
                    state_s    = ST_LOCKED;
                    lock_cnt_s = '0;
                end else begin
                    lock_cnt_s = lock_cnt_r + LOCK_ONE;
                end
            end
`endif
            default: begin
                state_s = ST_LOCKED;
            end
        endcase
    end

    // Step prescaler: free-runs only while UNLOCKED, parked at zero otherwise.
    always_comb begin
        presc_s = '0;
        if (state_r == ST_UNLOCKED) begin
            if (presc_r == PRESC_LAST) begin
                presc_s = '0;
            end else begin
                presc_s = presc_r + PRESC_ONE;
            end
        end else begin
            presc_s = '0;
        end
    end

    // Setpoint next value: load beats tick; ramp saturates at ideal, never wraps.
    always_comb begin
        set_s = set_r;
        for (int k = 0; k < CH; k++) begin
            if (load_ok_s) begin
                set_s[k*W +: W] = sens[k*W +: W];
            end else if (tick_s) begin
                if (set_r[k*W +: W] < ideal[k*W +: W]) begin
                    set_s[k*W +: W] = set_r[k*W +: W] + STEP_ONE;
                end else if (set_r[k*W +: W] > ideal[k*W +: W]) begin
                    set_s[k*W +: W] = set_r[k*W +: W] - STEP_ONE;
                end else begin
                    set_s[k*W +: W] = set_r[k*W +: W];
                end
            end else begin
                set_s[k*W +: W] = set_r[k*W +: W];
            end
        end
    end

    // Core state registers: FSM, prescaler, setpoints, unlocked flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_LOCKED;
            presc_r    <= '0;
            set_r      <= '0;
            unlocked_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            presc_r    <= presc_s;
            set_r      <= set_s;
            unlocked_r <= (state_s == ST_UNLOCKED);
        end
    end

`ifdef COMFORT_LOCKOUT_EN
    // Lockout bookkeeping registers: fail counter, lockout timer, status flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt_r   <= '0;
            lock_cnt_r   <= '0;
            locked_out_r <= 1'b0;
        end else begin
            fail_cnt_r   <= fail_cnt_s;
            lock_cnt_r   <= lock_cnt_s;
            locked_out_r <= (state_s == ST_LOCKOUT);
        end
    end

    assign locked_out = locked_out_r;
`else
    assign locked_out = 1'b0;
`endif

    // Busy per channel: ramp still pending while access is granted.
    always_comb begin
        busy_s = '0;
        for (int k = 0; k < CH; k++) begin
            busy_s[k] = unlocked_r && (set_r[k*W +: W] != ideal[k*W +: W]);
        end
    end

    assign set_out  = set_r;
    assign busy     = busy_s;
    assign unlocked = unlocked_r;

endmodule
